// File: rtl/flightline_pkg.sv
// -----------------------------------------------------------------------------
// flightline_pkg
// Shared types for the flight-line hazard-light sequencer.
//   mode_t       : light pattern code, also consumed by the hazard-light FSM
//   ctrl_state_t : mode scheduler state (IDLE / DWELL / OVRD)
//   decode_mode  : maps a raw 2-bit request code onto mode_t (11 -> CALM)
// -----------------------------------------------------------------------------
package flightline_pkg;

    typedef enum logic [1:0] {
        MODE_CALM = 2'b00,
        MODE_R2L  = 2'b01,
        MODE_L2R  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        OVRD
    } ctrl_state_t;

    localparam int NUM_REQ = 2;

    // The unused code 11 is folded onto CALM so a bad request can never
    // leave the lights in an undefined pattern.
    function automatic mode_t decode_mode(input logic [1:0] code);
        mode_t m;
        case (code)
            2'b01:   m = MODE_R2L;
            2'b10:   m = MODE_L2R;
            default: m = MODE_CALM;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flightline_mode_ctrl_step_divider.sv
// -----------------------------------------------------------------------------
// step_divider
// Free-running tick counter producing the pattern-advance enable.
//   clk   : clock
//   reset : asynchronous, active-high
//   clr   : restart the count at 0 on the next edge
//   step  : high for the one cycle in which count == TICK_DIV-1
// -----------------------------------------------------------------------------
module step_divider #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic step
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;

    always_comb begin
        count_next = count_reg + TICK_ONE;
        if (clr || (count_reg == TICK_LAST)) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign step = (count_reg == TICK_LAST);

endmodule

// File: rtl/flightline_mode_ctrl.sv
// -----------------------------------------------------------------------------
// flightline_mode_ctrl
// Mode scheduler and step-rate generator for the hazard-light sequencer.
// Two control stations (0 tower, 1 ground crew) request light modes; requests
// are granted round-robin from IDLE, a changed mode is held for MIN_DWELL
// steps, and a maintenance override forces CALM from any state.
//   clk       : clock
//   reset     : asynchronous, active-high
//   req_valid : per-requester request valid
//   req_mode  : [1:0] requester 0 mode, [3:2] requester 1 mode
//   req_ready : one-hot combinational grant pulse
//   override  : maintenance override, forces CALM
//   mode      : registered mode code (00 CALM, 01 R2L, 10 L2R)
//   step      : one-cycle advance enable for the light FSM
//   busy      : high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module flightline_mode_ctrl
    import flightline_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int MIN_DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_mode,
    output logic [1:0] req_ready,
    input  logic       override,
    output logic [1:0] mode,
    output logic       step,
    output logic       busy
);

    localparam int DW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

    ctrl_state_t   state_reg, state_next;
    mode_t         mode_reg, mode_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          last_reg, last_next;   // requester granted most recently

    logic          tick_clr;
    logic          step_int;
    logic [1:0]    grant;
    logic          grant_sel;
    mode_t         granted_mode;
    mode_t         req_mode_dec [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign req_mode_dec[gi] = decode_mode(req_mode[2*gi +: 2]);
        end
    endgenerate

    step_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_step_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .step  (step_int)
    );

    // Round-robin arbiter. Grants only from IDLE with override low; the
    // reset term keeps req_ready quiet while reset is held, since IDLE would
    // otherwise grant combinationally.
    always_comb begin
        grant     = 2'b00;
        grant_sel = 1'b0;
        if (req_valid == 2'b11) begin
            grant_sel = ~last_reg;
        end else begin
            grant_sel = req_valid[1];
        end
        if (!reset && !override && (state_reg == IDLE) && (req_valid != 2'b00)) begin
            grant = 2'b01 << grant_sel;
        end
    end

    assign granted_mode = req_mode_dec[grant_sel];

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        dwell_next = dwell_reg;
        last_next  = last_reg;
        tick_clr   = 1'b0;
        if (override) begin
            // Override wins over any grant or dwell step in the same cycle.
            // The tick phase is kept if the lights are already CALM so the
            // pattern cadence is not disturbed.
            state_next = OVRD;
            mode_next  = MODE_CALM;
            dwell_next = '0;
            tick_clr   = (mode_reg != MODE_CALM);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant != 2'b00) begin
                        last_next = grant_sel;
                        // A same-mode grant is acknowledged but changes nothing.
                        if (granted_mode != mode_reg) begin
                            mode_next  = granted_mode;
                            tick_clr   = 1'b1;
                            dwell_next = DWELL_LOAD;
                            if (MIN_DWELL != 0) begin
                                state_next = DWELL;
                            end
                        end
                    end
                end
                DWELL: begin
                    if (step_int) begin
                        dwell_next = dwell_reg - DWELL_ONE;
                        if (dwell_reg == DWELL_ONE) begin
                            state_next = IDLE;
                        end
                    end
                end
                OVRD: begin
                    // Release goes straight to IDLE; no dwell after override.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_CALM;
            dwell_reg <= '0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            dwell_reg <= dwell_next;
            last_reg  <= last_next;
        end
    end

    assign req_ready = grant;
    assign mode      = mode_reg;
    assign step      = step_int;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/flightline_mode_ctrl.md
# flightline_mode_ctrl

Mode scheduler and step-rate generator for the flight-line hazard-light sequencer. It arbitrates mode requests from two control stations (tower, ground crew), applies a maintenance override and enforces a minimum dwell per mode. It presents the hazard-light FSM with a 2-bit mode code and a single-cycle `step` enable that paces pattern advance.

## Interface
- `TICK_DIV`, default 25_000_000: clk cycles per `step` pulse; ≥2.
- `MIN_DWELL`, default 4: `step` pulses a newly applied mode must hold before another request is granted; 0 disables dwell.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 2: bit i = requester i (0 tower, 1 ground) presents a mode.
- `req_mode` in 4: [1:0] requester 0 mode, [3:2] requester 1 mode.
- `req_ready` out 2: one-hot, combinational grant pulse.
- `override` in 1: maintenance override; forces CALM.
- `mode` out 2: registered; 00 CALM, 01 R2L, 10 L2R.
- `step` out 1: one-cycle advance enable for the light FSM.
- `busy` out 1: high when the state is not IDLE.

## Operation
- States: IDLE, DWELL, OVRD.
- Requester protocol: hold `req_valid` and `req_mode` stable until `req_ready`. A transfer occurs when valid and ready are both high in the same cycle. Requesters are never dropped.
- Mode code 11 is treated as CALM (00).
- IDLE, override low, any valid: grant in the same cycle.
  - Round-robin: if both are valid, grant the requester not granted last.
  - Grant pointer resets to "last = 1", so requester 0 wins first.
- Granted mode differs from `mode`:
  - `mode` loads on the next edge.
  - Tick counter clears to 0.
  - Dwell counter loads `MIN_DWELL`.
  - Go to DWELL; if `MIN_DWELL` = 0, stay in IDLE.
- Granted mode equals `mode`: ready still pulses. No mode change, no counter clear, stay in IDLE.
- DWELL:
  - Dwell counter decrements on each `step`.
  - The step that takes it to 0 returns the state to IDLE on the next edge.
  - `req_ready` = 0 throughout.
- `override` high in any state:
  - Next edge: state OVRD, `mode` = CALM.
  - Tick counter clears only if `mode` was not already CALM.
  - `req_ready` = 0 while in OVRD.
  - Override deassert: next edge goes to IDLE with no dwell, and pending requests are granted from IDLE.
- Override has priority over a grant in the same cycle: no ready pulse is issued.
- Tick counter:
  - Counts 0..`TICK_DIV`-1, then wraps.
  - `step` = 1 while count == `TICK_DIV`-1.
  - Free-running in all states.
  - Width is $clog2(`TICK_DIV`).
- Dwell counter width is $clog2(`MIN_DWELL`+1); minimum 1 bit.

## Timing
- Reset values: `mode` = 00, `step` = 0, `req_ready` = 0, `busy` = 0, state IDLE, tick = 0, dwell = 0, round-robin last = 1.
- First `step` occurs in the `TICK_DIV`-th cycle after reset release.
- Grant to mode change: `req_ready` in cycle N, new `mode` visible in cycle N+1.
- After a mode change, the first `step` occurs `TICK_DIV` cycles after the change edge.
- Reset mid-DWELL or mid-OVRD returns all state to reset values immediately; no pending grant survives.
- `step` coinciding with the override edge: the dwell decrement is discarded and OVRD is entered.

## Structure
- Shared package `flightline_pkg`:
  - `mode_t` enum: `MODE_CALM` = 2'b00, `MODE_R2L` = 2'b01, `MODE_L2R` = 2'b10. This is also used by the hazard-light FSM.
  - `ctrl_state_t` enum: IDLE, DWELL, OVRD.
- Sub-module `step_divider`, parameterized by `TICK_DIV`:
  - Inputs: clk, reset, `clr`.
  - Output: `step`.
- The arbiter, dwell counter and FSM live in the top module.

## Test plan
(All scenarios use `TICK_DIV` = 4, `MIN_DWELL` = 2.)
- Reset release, no requests → `mode` = 00, `busy` = 0, `step` high in cycles 4, 8, 12 after release.
- `req_valid` = 01, `req_mode` = 01 →
  - `req_ready` = 01 in the same cycle.
  - `mode` = 01 and `busy` = 1 in the next cycle.
  - `step` 4 cycles after the change.
  - `busy` = 0 after the 2nd step.
- Both valid (requester 0 → 10, requester 1 → 01) →
  - Requester 0 granted, `mode` = 10.
  - Requester 1 held through dwell, then granted in the first IDLE cycle, `mode` = 01.
- Override raised mid-DWELL with `mode` = 10 →
  - `mode` = 00 on the next edge, `req_ready` = 00 while high.
  - On release, IDLE, and the pending request is granted without dwell wait.
- Same-mode request (`mode` = 00, request 00), then request 11 →
  - Each gets a ready pulse.
  - `mode` stays 00, `busy` stays 0, `step` cadence is unbroken.
- Reset asserted mid-DWELL → all outputs at reset values within the same cycle; pending requester re-granted after release.
